// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Merges the ID load-use bubble and multi-cycle EX ops into one per-stage hold
// vector. Multi-cycle ops are sequenced by a down-counter FSM. A saturating
// counter tracks the number of stalled cycles.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id_i,
    input  logic              ex_mc_start_i,
    input  logic [CNT_W-1:0]  ex_mc_cycles_i,
    input  logic              flush_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              ex_mc_done_o,
    output logic              busy_o,
    output logic [PERF_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERF_W-1:0]   perf_q, perf_d;
    logic [CNT_W-1:0]    one_c;

    assign one_c = {{(CNT_W-1){1'b0}}, 1'b1};

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    // Next-state logic: the counter holds the BUSY cycles still to go.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (ex_mc_start_i) begin
                    if (ex_mc_cycles_i <= one_c) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = ex_mc_cycles_i - one_c;
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == one_c) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - one_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode with priority flush > EX > ID; all outputs quiet in reset.
    always_comb begin
        stall_o      = '0;
        flush_o      = 1'b0;
        ex_mc_done_o = 1'b0;
        busy_o       = 1'b0;
        if (rst) begin
            busy_o = (state_q != IDLE);
            if (flush_i) begin
                flush_o = 1'b1;
            end else begin
                if ((state_q == IDLE && ex_mc_start_i) || state_q == BUSY) begin
                    stall_o = STALL_EX;
                end else if (stallreq_id_i) begin
                    stall_o = STALL_ID;
                end
                ex_mc_done_o = (state_q == DONE);
            end
        end
    end

    // Saturating stall-cycle counter; flush cycles never stall so are not counted.
    always_comb begin
        perf_d = perf_q;
        if (stall_o != 6'b0 && perf_q != '1) begin
            perf_d = perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles_o = perf_q;

endmodule
